// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode/issue pipeline: ALU control codes,
// opcode/funct encodings, the issue-state enum and the ID/EX bundle.
package pipeline_pkg;

  localparam int XLEN = 32;

  // ALU control codes seen by the execute stage (unlisted codes pass B).
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Primary opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct codes.
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  // Load-use interlock states.
  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_LOADPEND = 1'b1
  } issue_state_e;

  // Combinational decode result for one instruction word.
  typedef struct packed {
    logic [2:0]      alu_ctrl;
    logic            b_imm;      // 1: operand B is imm_ext, 0: rt_data
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      dest;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic            illegal;
    logic            reads_rs;
    logic            reads_rt;
  } decode_t;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [2:0]      alu_ctrl;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            is_branch;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } idex_t;

  localparam idex_t IDEX_RESET = '{
    alu_a:     '0,
    alu_b:     '0,
    alu_ctrl:  ALU_PASSB,
    rd:        '0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    is_branch: 1'b0,
    illegal:   1'b0,
    pc:        '0
  };

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational instruction decoder: produces the ALU control code,
// operand-B selection/immediate, destination, control flags and the
// register-read usage needed by the load-use interlock.
module alu_ctrl_decode
  import pipeline_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output decode_t         o_dec
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [4:0]  w_unused_rs;

  assign w_opcode    = i_instr[31:26];
  assign w_rt        = i_instr[20:16];
  assign w_rd        = i_instr[15:11];
  assign w_funct     = i_instr[5:0];
  assign w_imm       = i_instr[15:0];
  // rs is only compared in the top-level interlock, never decoded here.
  assign w_unused_rs = i_instr[25:21];

  // Decode opcode/funct into control; unknown encodings become illegal PASSB.
  always_comb begin
    o_dec          = '0;
    o_dec.alu_ctrl = ALU_PASSB;
    o_dec.reads_rs = 1'b1;
    case (w_opcode)
      OP_RTYPE: begin
        o_dec.reads_rt  = 1'b1;
        o_dec.dest      = w_rd;
        o_dec.reg_write = 1'b1;
        case (w_funct)
          FN_ADD:  o_dec.alu_ctrl = ALU_ADD;
          FN_SUB:  o_dec.alu_ctrl = ALU_SUB;
          FN_AND:  o_dec.alu_ctrl = ALU_AND;
          FN_OR:   o_dec.alu_ctrl = ALU_OR;
          default: begin
            o_dec.illegal   = 1'b1;
            o_dec.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        o_dec.alu_ctrl  = ALU_ADD;
        o_dec.b_imm     = 1'b1;
        o_dec.imm_ext   = {{16{w_imm[15]}}, w_imm};
        o_dec.dest      = w_rt;
        o_dec.reg_write = 1'b1;
      end
      OP_ANDI: begin
        o_dec.alu_ctrl  = ALU_AND;
        o_dec.b_imm     = 1'b1;
        o_dec.imm_ext   = {16'h0000, w_imm};
        o_dec.dest      = w_rt;
        o_dec.reg_write = 1'b1;
      end
      OP_ORI: begin
        o_dec.alu_ctrl  = ALU_OR;
        o_dec.b_imm     = 1'b1;
        o_dec.imm_ext   = {16'h0000, w_imm};
        o_dec.dest      = w_rt;
        o_dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        o_dec.alu_ctrl  = ALU_PASSB;
        o_dec.b_imm     = 1'b1;
        o_dec.imm_ext   = {w_imm, 16'h0000};
        o_dec.dest      = w_rt;
        o_dec.reg_write = 1'b1;
        o_dec.reads_rs  = 1'b0;
      end
      OP_LW: begin
        o_dec.alu_ctrl  = ALU_ADD;
        o_dec.b_imm     = 1'b1;
        o_dec.imm_ext   = {{16{w_imm[15]}}, w_imm};
        o_dec.dest      = w_rt;
        o_dec.reg_write = 1'b1;
        o_dec.mem_read  = 1'b1;
      end
      OP_SW: begin
        o_dec.alu_ctrl  = ALU_ADD;
        o_dec.b_imm     = 1'b1;
        o_dec.imm_ext   = {{16{w_imm[15]}}, w_imm};
        o_dec.dest      = w_rt;
        o_dec.mem_write = 1'b1;
        o_dec.reads_rt  = 1'b1;
      end
      OP_BEQ: begin
        o_dec.alu_ctrl  = ALU_SUB;
        o_dec.dest      = w_rt;
        o_dec.is_branch = 1'b1;
        o_dec.reads_rt  = 1'b1;
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
    // Register 0 is hard-wired; writes to it are suppressed.
    if (o_dec.dest == 5'd0) begin
      o_dec.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes the instruction, forms ALU operands
// and holds them in the ID/EX register behind a valid/ready handshake.
// Optional load-use interlock (one bubble) when ALU_ISSUE_LOAD_INTERLOCK_EN
// is defined; otherwise stall is tied low and no interlock state exists.
module alu_issue_stage
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_alu_a,
  output logic [XLEN-1:0] out_alu_b,
  output logic [2:0]      out_alu_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_is_branch,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  decode_t w_dec;
  idex_t   w_idex_next;
  idex_t   r_idex;
  logic    r_out_valid;
  logic    w_stall;
  logic    w_accept;

  alu_ctrl_decode u_decode (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  // Build the ID/EX bundle for the instruction currently offered by decode.
  always_comb begin
    w_idex_next           = IDEX_RESET;
    w_idex_next.alu_a     = rs_data;
    w_idex_next.alu_b     = w_dec.b_imm ? w_dec.imm_ext : rt_data;
    w_idex_next.alu_ctrl  = w_dec.alu_ctrl;
    w_idex_next.rd        = w_dec.dest;
    w_idex_next.reg_write = w_dec.reg_write;
    w_idex_next.mem_read  = w_dec.mem_read;
    w_idex_next.mem_write = w_dec.mem_write;
    w_idex_next.is_branch = w_dec.is_branch;
    w_idex_next.illegal   = w_dec.illegal;
    w_idex_next.pc        = in_pc;
  end

  assign in_ready = (!r_out_valid || out_ready) && !w_stall;
  assign w_accept = in_valid && in_ready;

  // ID/EX register: flush squashes, accept loads, a drained slot empties;
  // payload only changes on accept so a stalled output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_idex      <= IDEX_RESET;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_idex      <= w_idex_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_alu_a     = r_idex.alu_a;
  assign out_alu_b     = r_idex.alu_b;
  assign out_alu_ctrl  = r_idex.alu_ctrl;
  assign out_rd        = r_idex.rd;
  assign out_reg_write = r_idex.reg_write;
  assign out_mem_read  = r_idex.mem_read;
  assign out_mem_write = r_idex.mem_write;
  assign out_is_branch = r_idex.is_branch;
  assign out_illegal   = r_idex.illegal;
  assign out_pc        = r_idex.pc;

`ifdef ALU_ISSUE_LOAD_INTERLOCK_EN
  issue_state_e r_state;
  issue_state_e w_state_next;
  logic [4:0]   r_pend_reg;
  logic [4:0]   w_pend_next;
  logic         w_dep_rs;
  logic         w_dep_rt;

  assign w_dep_rs = w_dec.reads_rs && (in_instr[25:21] == r_pend_reg);
  assign w_dep_rt = w_dec.reads_rt && (in_instr[20:16] == r_pend_reg);
  assign w_stall  = (r_state == ST_LOADPEND) && in_valid && (w_dep_rs || w_dep_rt);

  // Interlock state and pending load destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_NORMAL;
      r_pend_reg <= 5'd0;
    end else begin
      r_state    <= w_state_next;
      r_pend_reg <= w_pend_next;
    end
  end

  // Next state: a load to a real register arms the interlock; the load
  // leaving, any other accept, or a flush disarms it.
  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend_reg;
    if (flush) begin
      w_state_next = ST_NORMAL;
    end else if (w_accept) begin
      if (w_dec.mem_read && (in_instr[20:16] != 5'd0)) begin
        w_state_next = ST_LOADPEND;
        w_pend_next  = in_instr[20:16];
      end else begin
        w_state_next = ST_NORMAL;
      end
    end else if (r_out_valid && out_ready) begin
      w_state_next = ST_NORMAL;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{w_dec.reads_rs, w_dec.reads_rt};
  assign w_stall     = 1'b0;
`endif

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue stage: takes a fetched instruction plus register-file operands, generates the 3-bit ALU control code and operand selection consumed by the execute-stage ALU, and holds the result in the ID/EX pipeline register. It is the producer side of the ALU control interface. It provides a valid/ready handshake toward execute, a synchronous flush, and an optional load-use interlock that inserts one bubble.

## Interface
- `XLEN`, 32, datapath and instruction width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in XLEN: instruction word. Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0].
- `in_pc` in XLEN: instruction PC.
- `rs_data`, `rt_data` in XLEN: register-file read data.
- `flush` in 1: squash the held and incoming instruction.
- `out_valid` out 1 / `out_ready` in 1: handshake toward execute.
- `out_alu_a`, `out_alu_b` out XLEN: ALU operands.
- `out_alu_ctrl` out 3: ALU control code.
- `out_rd` out 5: destination register.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_is_branch`, `out_illegal` out 1: control flags.
- `out_pc` out XLEN: PC passed through.

## Operation
- ALU codes: ADD=000, SUB=010, AND=110, OR=100, PASSB=111. Any non-listed code at the ALU passes B.
- R-type (opcode 000000), with A=rs_data, B=rt_data, dest rd, reg_write=1:
  - funct 100000 → ADD
  - funct 100010 → SUB
  - funct 100100 → AND
  - funct 100101 → OR
  - any other funct → illegal
- I-type, with A=rs_data and dest rt:
  - addi 001000 → ADD, B=sign-extended imm
  - andi 001100 → AND, B=zero-extended imm
  - ori 001101 → OR, B=zero-extended imm
  - lui 001111 → PASSB, B={imm,16'h0}
  - lw 100011 → ADD, B=sign-extended imm, mem_read=1, reg_write=1
  - sw 101011 → ADD, B=sign-extended imm, mem_write=1, reg_write=0, out_rd=rt
  - beq 000100 → SUB, B=rt_data, is_branch=1, reg_write=0
- Illegal opcode or funct: PASSB, all write/mem/branch flags 0, out_illegal=1.
- Destination 0 forces reg_write=0.
- Pipeline register:
  - `in_ready = (!out_valid || out_ready) && !stall`.
  - On `in_valid && in_ready` the register loads the decoded fields and sets out_valid=1.
  - If out_ready is high and nothing is accepted, out_valid clears.
  - While `out_valid && !out_ready`, the register holds all outputs stable.
- Flush:
  - Next edge: out_valid=0 and load-pending is cleared.
  - Overrides any same-cycle acceptance; an instruction handshaken in the flush cycle is dropped.
- Interlock states (when enabled): NORMAL and LOADPEND.
  - NORMAL → LOADPEND when an accepted lw has rt≠0; pend_reg=rt.
  - In LOADPEND, stall=1 when in_valid and the incoming instruction reads pend_reg. rs is read by all types except lui; rt is read by R-type, sw and beq.
  - LOADPEND → NORMAL on the first edge where out_valid && out_ready, i.e. the load leaves. Also on acceptance of any non-dependent instruction, or on flush.
  - A stalled consumer sees in_ready=0. In the cycle the load leaves, the register loads a bubble (out_valid=0). The consumer is accepted the following cycle.
  - An accepted non-dependent lw re-enters LOADPEND with the new rt.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle when out_ready is held high.
- Load-use penalty: exactly one bubble cycle.
- Reset values: out_valid=0, all flags 0, out_alu_ctrl=111, operands/out_rd/out_pc=0, state NORMAL.
- Reset mid-transfer discards the held instruction; no output toggles until the first post-reset accept.
- in_ready is combinational from out_valid, out_ready, state, in_valid and in_instr. No other comb path goes in→out.

## Configuration
- `ALU_ISSUE_LOAD_INTERLOCK_EN` defined: the LOADPEND state machine and stall are present as above.
- Not defined: stall is tied to 0 and no state register exists. Load-use scheduling is software's responsibility; a dependent instruction issues back-to-back.

## Structure
- Shared package `pipeline_pkg` holds:
  - ALU code constants (ADD/SUB/AND/OR/PASSB)
  - opcode/funct constants
  - the issue-state enum
  - the ID/EX bundle struct
- One sub-module, `alu_ctrl_decode`: purely combinational instruction → {alu_ctrl, b_sel, imm_ext, flags, dest}. The top-level holds the pipeline register and interlock.

## Test plan
- add $3,$1,$2 with rs_data=5, rt_data=7, out_ready=1 → next cycle out_valid=1, ctrl=000, A=5, B=7, rd=3, reg_write=1.
- andi $4,$1,0xFFFF with rs_data=0x1234_5678 → ctrl=110, B=0x0000_FFFF. Then addi with imm 0xFFFF → ctrl=000, B=0xFFFF_FFFF.
- out_ready low for 3 cycles with in_valid high → outputs stable, in_ready=0. Release → one transfer per cycle, no loss or duplication.
- lw $5,0($1) then add $6,$5,$2 (interlock on) → exactly one out_valid=0 cycle between them. With the macro off → back-to-back issue.
- flush asserted in the same cycle as an accepted beq → next cycle out_valid=0. Subsequent instructions issue normally.
- opcode 111111 → out_illegal=1, ctrl=111, reg_write=0. rst_n low mid-stream → out_valid=0 immediately (asynchronous).
